// File: rtl/edge_detect_multi.sv
// rtl/edge_detect_multi.sv - multi-channel synchronizer, glitch filter and edge detector (optional EDGE_DETECT_STICKY_STATUS_EN)
module edge_detect_multi #(
    parameter int   NUM_CH        = 4,
    parameter int   SYNC_STAGES   = 2,
    parameter int   FILTER_CYCLES = 3,
    parameter logic RESET_LEVEL   = 1'b1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [NUM_CH-1:0] sig_in,
    input  logic [NUM_CH-1:0] rise_en,
    input  logic [NUM_CH-1:0] fall_en,
    output logic [NUM_CH-1:0] level_out,
    output logic [NUM_CH-1:0] rising_edge_found,
    output logic [NUM_CH-1:0] falling_edge_found,
    output logic              any_edge
`ifdef EDGE_DETECT_STICKY_STATUS_EN
    ,
    input  logic [NUM_CH-1:0] status_clr,
    output logic [NUM_CH-1:0] edge_status
`endif
);

    // Counter is wide enough to hold FILTER_CYCLES; never narrower than one bit.
    localparam int CNT_W = (FILTER_CYCLES < 1) ? 1 : $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] FILT_MAX = CNT_W'(FILTER_CYCLES);

    // Reject configurations that would give an unsafe or meaningless block.
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("edge_detect_multi: SYNC_STAGES must be at least 2");
    end
    if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_ch
        $error("edge_detect_multi: NUM_CH must be in 1..32");
    end
    if (FILTER_CYCLES < 0 || FILTER_CYCLES > 255) begin : g_bad_filt
        $error("edge_detect_multi: FILTER_CYCLES must be in 0..255");
    end

    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] s;
    logic [NUM_CH-1:0] rise_d;
    logic [NUM_CH-1:0] fall_d;

    // Metastability chain: sig_in enters stage 0 and ripples to the last stage.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= {NUM_CH{RESET_LEVEL}};
            end
        end else begin
            sync_q[0] <= sig_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt_q;
        logic             level_q;
        logic             rise_q;
        logic             fall_q;
        logic             flip;

        // The level only moves once the synchronized input has disagreed for FILTER_CYCLES+1 clocks.
        assign flip      = (s[i] != level_q) && (cnt_q == FILT_MAX);
        assign rise_d[i] = flip &  s[i] & rise_en[i];
        assign fall_d[i] = flip & ~s[i] & fall_en[i];

        // Filter counter, filtered level and registered edge pulses for this channel.
        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                cnt_q   <= '0;
                level_q <= RESET_LEVEL;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                rise_q <= rise_d[i];
                fall_q <= fall_d[i];
                if (s[i] == level_q) begin
                    cnt_q <= '0;
                end else if (flip) begin
                    level_q <= s[i];
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end

        assign level_out[i]          = level_q;
        assign rising_edge_found[i]  = rise_q;
        assign falling_edge_found[i] = fall_q;
    end

    assign any_edge = (|rising_edge_found) | (|falling_edge_found);

`ifdef EDGE_DETECT_STICKY_STATUS_EN
    logic [NUM_CH-1:0] status_q;

    // Sticky per-channel flag; a new edge wins over a same-cycle clear.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            status_q <= '0;
        end else begin
            status_q <= rise_d | fall_d | (status_q & ~status_clr);
        end
    end

    assign edge_status = status_q;
`endif

endmodule

// File: tb/tb_edge_detect_multi.sv
// tb/tb_edge_detect_multi.sv - self-checking bench for edge_detect_multi
module tb_edge_detect_multi;

    localparam int NUM_CH   = 4;
    localparam int SYNC     = 2;
    localparam int FILT     = 3;
    localparam int HIST_LEN = SYNC + FILT + 1;

    logic              clk;
    logic              n_rst;
    logic [NUM_CH-1:0] sig_in;
    logic [NUM_CH-1:0] rise_en;
    logic [NUM_CH-1:0] fall_en;
    logic [NUM_CH-1:0] level_out;
    logic [NUM_CH-1:0] rising_edge_found;
    logic [NUM_CH-1:0] falling_edge_found;
    logic              any_edge;
`ifdef EDGE_DETECT_STICKY_STATUS_EN
    logic [NUM_CH-1:0] status_clr;
    logic [NUM_CH-1:0] edge_status;
`endif

    int total = 0;
    int bad   = 0;

    edge_detect_multi #(
        .NUM_CH        (NUM_CH),
        .SYNC_STAGES   (SYNC),
        .FILTER_CYCLES (FILT),
        .RESET_LEVEL   (1'b1)
    ) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .sig_in             (sig_in),
        .rise_en            (rise_en),
        .fall_en            (fall_en),
        .level_out          (level_out),
        .rising_edge_found  (rising_edge_found),
        .falling_edge_found (falling_edge_found),
        .any_edge           (any_edge)
`ifdef EDGE_DETECT_STICKY_STATUS_EN
        ,
        .status_clr         (status_clr),
        .edge_status        (edge_status)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: keeps the raw input sampled at every edge; a channel's level
    // flips when the FILT+1 samples seen by the filter (delayed by SYNC edges) all
    // disagree with the current level.
    logic [NUM_CH-1:0] hist [HIST_LEN];
    logic [NUM_CH-1:0] m_level;
    logic [NUM_CH-1:0] m_rise;
    logic [NUM_CH-1:0] m_fall;
    logic [NUM_CH-1:0] m_status;

    always @(posedge clk or negedge n_rst) begin : ref_model
        logic [NUM_CH-1:0] h [HIST_LEN];
        logic [NUM_CH-1:0] lv;
        logic [NUM_CH-1:0] r;
        logic [NUM_CH-1:0] f;
        logic              all_diff;
        if (!n_rst) begin
            for (int j = 0; j < HIST_LEN; j++) hist[j] <= '1;
            m_level  <= '1;
            m_rise   <= '0;
            m_fall   <= '0;
            m_status <= '0;
        end else begin
            h[0] = sig_in;
            for (int j = 1; j < HIST_LEN; j++) h[j] = hist[j-1];
            lv = m_level;
            r  = '0;
            f  = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                all_diff = 1'b1;
                for (int j = SYNC; j <= SYNC + FILT; j++) begin
                    if (h[j][c] == m_level[c]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    lv[c] = ~m_level[c];
                    r[c]  = lv[c] & rise_en[c];
                    f[c]  = ~lv[c] & fall_en[c];
                end
            end
            for (int j = 0; j < HIST_LEN; j++) hist[j] <= h[j];
            m_level <= lv;
            m_rise  <= r;
            m_fall  <= f;
`ifdef EDGE_DETECT_STICKY_STATUS_EN
            m_status <= r | f | (m_status & ~status_clr);
`endif
        end
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        n_rst   = 1'b0;
        sig_in  = 4'hF;
        rise_en = 4'hF;
        fall_en = 4'hF;
`ifdef EDGE_DETECT_STICKY_STATUS_EN
        status_clr = 4'h0;
`endif
        @(negedge clk);
        tick;
        tick;
        total++;
        if (level_out !== 4'hF) begin
            bad++; $display("FAIL reset_level got=%h exp=%h", level_out, 4'hF);
        end
        total++;
        if ({rising_edge_found, falling_edge_found, any_edge} !== 9'd0) begin
            bad++; $display("FAIL reset_pulses got=%h/%h/%b exp=0", rising_edge_found, falling_edge_found, any_edge);
        end
`ifdef EDGE_DETECT_STICKY_STATUS_EN
        total++;
        if (edge_status !== 4'h0) begin
            bad++; $display("FAIL reset_status got=%h exp=0", edge_status);
        end
`endif
        n_rst = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick;
            total++;
            if (level_out !== 4'hF || rising_edge_found !== 4'h0 || falling_edge_found !== 4'h0 || any_edge !== 1'b0) begin
                bad++;
                $display("FAIL release_quiet cyc=%0d got lvl=%h r=%h f=%h any=%b exp lvl=f r=0 f=0 any=0",
                         k, level_out, rising_edge_found, falling_edge_found, any_edge);
            end
        end
    endtask

    task automatic test_fall_latency;
        sig_in[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick;
            total++;
            if (falling_edge_found[0] !== (k == 6) || any_edge !== (k == 6) || level_out[0] !== (k < 6)) begin
                bad++;
                $display("FAIL fall_latency cyc=%0d got f0=%b any=%b lvl0=%b exp f0=%b any=%b lvl0=%b",
                         k, falling_edge_found[0], any_edge, level_out[0], k == 6, k == 6, k < 6);
            end
        end
        sig_in[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick;
            total++;
            if (rising_edge_found[0] !== (k == 6) || falling_edge_found[0] !== 1'b0 || level_out[0] !== (k >= 6)) begin
                bad++;
                $display("FAIL rise_latency cyc=%0d got r0=%b f0=%b lvl0=%b exp r0=%b f0=0 lvl0=%b",
                         k, rising_edge_found[0], falling_edge_found[0], level_out[0], k == 6, k >= 6);
            end
        end
    endtask

    task automatic test_glitch;
        int n_fall;
        int n_rise;
        int fall_at;
        int rise_at;
        sig_in[1] = 1'b0;
        repeat (3) tick;
        sig_in[1] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick;
            total++;
            if (level_out[1] !== 1'b1 || any_edge !== 1'b0) begin
                bad++;
                $display("FAIL glitch3 cyc=%0d got lvl1=%b any=%b exp lvl1=1 any=0", k, level_out[1], any_edge);
            end
        end
        n_fall = 0; n_rise = 0; fall_at = 0; rise_at = 0;
        sig_in[1] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 5) sig_in[1] = 1'b1;
            tick;
            if (falling_edge_found[1]) begin n_fall++; fall_at = k; end
            if (rising_edge_found[1])  begin n_rise++; rise_at = k; end
        end
        total++;
        if (n_fall != 1 || n_rise != 1) begin
            bad++; $display("FAIL glitch4_count got fall=%0d rise=%0d exp fall=1 rise=1", n_fall, n_rise);
        end
        total++;
        if (!(fall_at < rise_at)) begin
            bad++; $display("FAIL glitch4_order got fall_at=%0d rise_at=%0d exp fall before rise", fall_at, rise_at);
        end
        total++;
        if (level_out[1] !== 1'b1) begin
            bad++; $display("FAIL glitch4_level got=%b exp=1", level_out[1]);
        end
    endtask

    task automatic test_enables;
        int n_fall;
        int n_rise;
        n_fall = 0; n_rise = 0;
        rise_en = 4'h0;
        fall_en = 4'hF;
        sig_in[2] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick;
            if (falling_edge_found[2]) n_fall++;
            if (rising_edge_found[2])  n_rise++;
        end
        total++;
        if (level_out[2] !== 1'b0) begin
            bad++; $display("FAIL en_level_low got=%b exp=0", level_out[2]);
        end
        sig_in[2] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick;
            if (falling_edge_found[2]) n_fall++;
            if (rising_edge_found[2])  n_rise++;
        end
        total++;
        if (level_out[2] !== 1'b1) begin
            bad++; $display("FAIL en_level_high got=%b exp=1", level_out[2]);
        end
        total++;
        if (n_fall != 1 || n_rise != 0) begin
            bad++; $display("FAIL en_gating got fall=%0d rise=%0d exp fall=1 rise=0", n_fall, n_rise);
        end
        rise_en = 4'hF;
    endtask

    task automatic test_simultaneous;
        sig_in = 4'b0110;
        for (int k = 1; k <= 8; k++) begin
            tick;
            total++;
            if (falling_edge_found !== ((k == 6) ? 4'b1001 : 4'b0000)) begin
                bad++; $display("FAIL simul_fall cyc=%0d got=%b exp=%b", k, falling_edge_found, (k == 6) ? 4'b1001 : 4'b0000);
            end
        end
        sig_in = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            tick;
            total++;
            if (rising_edge_found !== ((k == 6) ? 4'b1001 : 4'b0000)) begin
                bad++; $display("FAIL simul_rise cyc=%0d got=%b exp=%b", k, rising_edge_found, (k == 6) ? 4'b1001 : 4'b0000);
            end
        end
    endtask

    task automatic test_reset_mid;
        sig_in[2] = 1'b0;
        repeat (3) tick;
        n_rst = 1'b0;
        #1;
        total++;
        if (level_out !== 4'hF || rising_edge_found !== 4'h0 || falling_edge_found !== 4'h0 || any_edge !== 1'b0) begin
            bad++;
            $display("FAIL midreset_async got lvl=%h r=%h f=%h any=%b exp lvl=f r=0 f=0 any=0",
                     level_out, rising_edge_found, falling_edge_found, any_edge);
        end
        sig_in = 4'hF;
        @(negedge clk);
        tick;
        n_rst = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick;
            total++;
            if (any_edge !== 1'b0 || level_out !== 4'hF) begin
                bad++; $display("FAIL midreset_quiet cyc=%0d got any=%b lvl=%h exp any=0 lvl=f", k, any_edge, level_out);
            end
        end
        sig_in[2] = 1'b0;
        repeat (3) tick;
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick;
            total++;
            if (falling_edge_found[2] !== (k == 6)) begin
                bad++; $display("FAIL midreset_restart cyc=%0d got f2=%b exp=%b", k, falling_edge_found[2], k == 6);
            end
        end
        sig_in = 4'hF;
        repeat (8) tick;
    endtask

`ifdef EDGE_DETECT_STICKY_STATUS_EN
    task automatic test_status;
        status_clr = 4'hF;
        tick;
        status_clr = 4'b0010;
        sig_in[1]  = 1'b0;
        repeat (6) tick;
        total++;
        if (falling_edge_found[1] !== 1'b1 || edge_status[1] !== 1'b1) begin
            bad++; $display("FAIL status_set_wins got f1=%b st1=%b exp f1=1 st1=1", falling_edge_found[1], edge_status[1]);
        end
        status_clr = 4'h0;
        tick;
        total++;
        if (edge_status[1] !== 1'b1) begin
            bad++; $display("FAIL status_sticky got=%b exp=1", edge_status[1]);
        end
        status_clr = 4'b0010;
        tick;
        total++;
        if (edge_status[1] !== 1'b0) begin
            bad++; $display("FAIL status_clear got=%b exp=0", edge_status[1]);
        end
        status_clr = 4'h0;
        sig_in     = 4'hF;
        repeat (8) tick;
    endtask
`endif

    task automatic test_random;
        logic [NUM_CH-1:0] mask;
        for (int k = 0; k < 600; k++) begin
            mask   = NUM_CH'($urandom & $urandom);
            sig_in = sig_in ^ mask;
            if (k % 50 == 0) begin
                rise_en = NUM_CH'($urandom | $urandom);
                fall_en = NUM_CH'($urandom | $urandom);
            end
`ifdef EDGE_DETECT_STICKY_STATUS_EN
            status_clr = NUM_CH'($urandom & $urandom & $urandom);
`endif
            tick;
            total++;
            if (level_out !== m_level || rising_edge_found !== m_rise || falling_edge_found !== m_fall
                || any_edge !== (|{m_rise, m_fall})) begin
                bad++;
                $display("FAIL random cyc=%0d got lvl=%h r=%h f=%h any=%b exp lvl=%h r=%h f=%h any=%b",
                         k, level_out, rising_edge_found, falling_edge_found, any_edge,
                         m_level, m_rise, m_fall, |{m_rise, m_fall});
            end
`ifdef EDGE_DETECT_STICKY_STATUS_EN
            total++;
            if (edge_status !== m_status) begin
                bad++; $display("FAIL random_status cyc=%0d got=%h exp=%h", k, edge_status, m_status);
            end
`endif
        end
    endtask

    initial begin
        test_reset;
        test_fall_latency;
        test_glitch;
        test_enables;
        test_simultaneous;
        test_reset_mid;
`ifdef EDGE_DETECT_STICKY_STATUS_EN
        test_status;
`endif
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/edge_detect_multi.md
EDGE_DETECT_MULTI -- requirements
Module: edge_detect_multi

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent input channels, 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flops per channel, minimum 2; a value below 2 SHALL cause an elaboration error.
REQ-003 Parameter FILTER_CYCLES, default 3: glitch-filter length in clocks, 0..255; 0 disables filtering.
REQ-004 Parameter RESET_LEVEL, default 1'b1: idle level of every channel, matching I2C SCL/SDA idle-high.
REQ-005 clk  input  1  system clock; all state updates on the rising edge.
REQ-006 n_rst  input  1  asynchronous, active-low reset.
REQ-007 sig_in  input  NUM_CH  asynchronous raw inputs (e.g. SCL, SDA).
REQ-008 rise_en  input  NUM_CH  per-channel enable for rising-edge reporting.
REQ-009 fall_en  input  NUM_CH  per-channel enable for falling-edge reporting.
REQ-010 level_out  output  NUM_CH  filtered, synchronized level per channel.
REQ-011 rising_edge_found  output  NUM_CH  one-cycle pulse per channel on a filtered 0->1 transition.
REQ-012 falling_edge_found  output  NUM_CH  one-cycle pulse per channel on a filtered 1->0 transition.
REQ-013 any_edge  output  1  OR of all bits of rising_edge_found and falling_edge_found.

Function
REQ-014 Each channel SHALL pass sig_in through a SYNC_STAGES-deep flop chain; the last stage is s[i].
REQ-015 Each channel SHALL hold a filter counter cnt[i] of width clog2(FILTER_CYCLES+1), minimum 1 bit.
REQ-016 At each clock where s[i] == level_out[i], cnt[i] SHALL load 0.
REQ-017 At each clock where s[i] != level_out[i] and cnt[i] < FILTER_CYCLES, cnt[i] SHALL increment by 1.
REQ-018 At each clock where s[i] != level_out[i] and cnt[i] == FILTER_CYCLES, level_out[i] SHALL take s[i] and cnt[i] SHALL load 0.
REQ-019 Latency from sig_in change, stable before edge 1, to level_out change SHALL be exactly SYNC_STAGES+FILTER_CYCLES+1 rising edges (default 6).
REQ-020 A deviation of s[i] lasting FILTER_CYCLES clocks or fewer SHALL produce no level_out change and no edge pulse.
REQ-021 rising_edge_found[i] SHALL be a registered output, high for exactly one cycle, in the same cycle level_out[i] goes 0->1, and only if rise_en[i] is 1 at that clock edge.
REQ-022 falling_edge_found[i] SHALL follow the same rule for 1->0 transitions, gated by fall_en[i].
REQ-023 Disabling an enable SHALL suppress reporting only; filtering and level_out SHALL be unaffected.
REQ-024 Channels SHALL be fully independent; simultaneous edges on several channels SHALL all be reported in the same cycle.
REQ-025 any_edge SHALL be combinational from the registered edge outputs and SHALL add no latency.

Reset
REQ-026 While n_rst is 0: all synchronizer flops and level_out SHALL be RESET_LEVEL, cnt SHALL be 0, and all edge outputs, any_edge and status SHALL be 0.
REQ-027 Assertion of n_rst mid-operation SHALL take effect immediately, discarding in-progress filter counts.
REQ-028 No edge pulse SHALL be generated by reset release when sig_in equals RESET_LEVEL.

Configuration
REQ-029 With macro EDGE_DETECT_STICKY_STATUS_EN defined, the block SHALL add input status_clr[NUM_CH] and output edge_status[NUM_CH].
REQ-030 With the macro defined, edge_status[i] SHALL set on any reported edge of channel i, clear when status_clr[i] is 1, and set in preference to clear when both occur on the same clock.
REQ-031 Without the macro, neither port nor its register SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-032 Reset, then sig_in held at 4'hF -> all outputs 0, level_out 4'hF, no pulses after release.
REQ-033 Defaults; sig_in[0] 1->0 held -> falling_edge_found[0] and any_edge high for one cycle exactly 6 clocks later; level_out[0]=0.
REQ-034 sig_in[1] low for 3 clocks then back high (FILTER_CYCLES=3) -> no pulse, level_out[1] stays 1; a 4-clock low -> one falling pulse followed by one rising pulse.
REQ-035 rise_en=0, fall_en=4'hF; toggle channel 2 low then high -> only the falling pulse is reported; level_out[2] tracks both transitions.
REQ-036 Channels 0 and 3 toggle on the same clock -> both pulses appear in the same cycle; n_rst asserted mid-filter -> cnt cleared, no pulse.
REQ-037 With EDGE_DETECT_STICKY_STATUS_EN defined: edge on channel 1 with status_clr[1]=1 on the same cycle -> edge_status[1]=1; clear on a later cycle -> 0.
